operand_fetch: RTL and testbench
================================

# operand_fetch

Initiator-side read sequencer for the triple-ported register file: accepts decoded source-register requests over a valid/ready handshake, drives the register file's two read ports, waits out the fixed read latency, and presents both operands downstream. It merges in-flight writeback data so a returned operand always reflects the newest write, and it forces register 0 to zero. It sits between decode and execute, on the read side of the register file's write-back port.

## Interface
- DATA_WIDTH, 32, operand width
- ADDR_WIDTH, 5, register address width
- READ_LAT, 2, cycles from first address edge to register-file data valid (≥1)

- iClk  in  1  sole clock
- iRst_n  in  1  asynchronous, active-low reset
- iFlush  in  1  synchronous abort, highest priority
- iReqValid  in  1  request valid
- oReqReady  out  1  request accepted when high with iReqValid
- iReqAddr0 / iReqAddr1  in  ADDR_WIDTH  source register addresses
- iReqUse0 / iReqUse1  in  1  operand needed
- oOpValid  out  1  operands valid
- iOpReady  in  1  downstream accepts
- oOp0 / oOp1  out  DATA_WIDTH  operands
- oAddrRead0 / oAddrRead1  out  ADDR_WIDTH  to register file read ports
- oEnRead0 / oEnRead1  out  1  to register file read enables
- iDataRead0 / iDataRead1  in  DATA_WIDTH  from register file
- iWbEn  in  1  writeback to register file this cycle
- iWbAddr  in  ADDR_WIDTH  writeback address
- iWbData  in  DATA_WIDTH  writeback data

## Operation
- FSM states IDLE, WAIT, HOLD. Reset → IDLE.
- IDLE: oReqReady=1. On iReqValid: latch addresses/uses, load latency counter with READ_LAT, → WAIT.
- WAIT: oReqReady=0; oAddrReadN = latched address, oEnReadN = latched use, both held constant for the whole state. Counter decrements each cycle; at the edge where it reaches 0, capture operands, → HOLD.
- HOLD: oOpValid=1, oOpN held. On iOpReady → IDLE, oEnReadN=0.
- Operand value: use=0 or address 0 → 0; else bypass data if a matching writeback was seen, else iDataReadN.
- Bypass: a writeback matches when iWbEn, iWbAddr≠0, and iWbAddr equals the operand's address with use=1. Matches are checked in IDLE on the accepting cycle (against iReqAddrN), and in every WAIT and HOLD cycle. The latest match wins. A match on the capture edge overrides iDataReadN. A match in HOLD updates oOpN in place.
- iFlush: → IDLE next edge, oOpValid=0, read enables low, bypass flags cleared; overrides acceptance and output handshake.
- Reset values: oReqReady=1, oOpValid=0, oOp0/1=0, oAddrRead0/1=0, oEnRead0/1=0, counter 0, bypass flags 0.
- Reset asserted mid-operation discards the transaction immediately (asynchronous).

## Timing
- Accept at edge T. Addresses and enables are valid from T through T+READ_LAT. Capture happens at edge T+READ_LAT. oOpValid is high from T+READ_LAT.
- Minimum request-to-request spacing is READ_LAT+2 cycles with iOpReady held high.
- oReqReady and oOpValid are decoded from registered state only. There are no combinational input-to-output paths, except that a HOLD writeback appears on oOpN one edge later.

## Structure
- operand_fetch_pkg (shared include): state encodings, REG_ZERO address constant.
- Sub-module operand_slot, instantiated twice: latched address/use, bypass flag/data, capture mux, zero-forcing. The top level owns the FSM, counter and handshakes.

## Test plan
- Read: regfile r3=0xA5A5_0003, r7=0x0000_0077. Request (3,7), iOpReady=1 → oOpValid at T+2 with oOp0=0xA5A5_0003, oOp1=0x77; oAddrRead stable during WAIT.
- Zero/unused: request (0,5) with use1=0 → oOp0=0, oOp1=0, oEnRead1=0; a writeback to r0 of 0xFFFF_FFFF changes nothing.
- Bypass: request (9,9); writeback r9=0x1234 in WAIT cycle 1 and r9=0x5678 on the capture edge → both operands 0x5678.
- Backpressure: iOpReady low 4 cycles in HOLD, writeback r9=0xBEEF → oOp0 updates to 0xBEEF; oReqReady stays 0 until the handshake.
- Flush/reset: iFlush in WAIT → IDLE next cycle, oOpValid never asserts. iRst_n low in HOLD → all outputs at reset values immediately.
- Back-to-back: iReqValid held high with varying addresses → accepts spaced exactly READ_LAT+2 cycles; every operand correct against a reference model.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch sequencer: FSM encoding and the
// hard-wired zero register address.
package operand_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned REG_ZERO = 32'd0;

endpackage

// File: rtl/operand_fetch_slot.sv
// One operand lane: latched source address/use, writeback bypass tracking,
// capture mux with r0 forcing, and the held operand register.
module operand_slot
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iFlush,
  input  logic                  iLoad,
  input  logic                  iActive,
  input  logic                  iCapture,
  input  logic                  iHold,
  input  logic                  iRelease,
  input  logic [ADDR_WIDTH-1:0] iReqAddr,
  input  logic                  iReqUse,
  input  logic                  iWbEn,
  input  logic [ADDR_WIDTH-1:0] iWbAddr,
  input  logic [DATA_WIDTH-1:0] iWbData,
  input  logic [DATA_WIDTH-1:0] iDataRead,
  output logic [ADDR_WIDTH-1:0] oAddrRead,
  output logic                  oEnRead,
  output logic [DATA_WIDTH-1:0] oOp
);

  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  use_r;
  logic                  en_r;
  logic                  bypValid_r;
  logic [DATA_WIDTH-1:0] bypData_r;
  logic [DATA_WIDTH-1:0] op_r;
  logic                  reqHit_s;
  logic                  latHit_s;
  logic                  hit_s;
  logic [DATA_WIDTH-1:0] capVal_s;

  // Writeback match detection and capture value selection (newest data wins)
  always_comb begin
    reqHit_s = iLoad && iReqUse && (iWbAddr == iReqAddr);
    latHit_s = iActive && use_r && (iWbAddr == addr_r);
    hit_s    = iWbEn && (iWbAddr != ADDR_WIDTH'(REG_ZERO)) && (reqHit_s || latHit_s);
    if (!use_r || (addr_r == ADDR_WIDTH'(REG_ZERO))) begin
      capVal_s = {DATA_WIDTH{1'b0}};
    end else if (hit_s) begin
      capVal_s = iWbData;
    end else if (bypValid_r) begin
      capVal_s = bypData_r;
    end else begin
      capVal_s = iDataRead;
    end
  end

  // Request latch, bypass record, read enable and operand register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      addr_r     <= {ADDR_WIDTH{1'b0}};
      use_r      <= 1'b0;
      en_r       <= 1'b0;
      bypValid_r <= 1'b0;
      bypData_r  <= {DATA_WIDTH{1'b0}};
      op_r       <= {DATA_WIDTH{1'b0}};
    end else if (iFlush) begin
      en_r       <= 1'b0;
      bypValid_r <= 1'b0;
    end else begin
      if (iLoad) begin
        addr_r     <= iReqAddr;
        use_r      <= iReqUse;
        en_r       <= iReqUse;
        bypValid_r <= hit_s;
        bypData_r  <= iWbData;
      end else if (hit_s) begin
        bypValid_r <= 1'b1;
        bypData_r  <= iWbData;
      end
      if (iRelease) begin
        en_r <= 1'b0;
      end
      // In HOLD a matching writeback refreshes the presented operand in place
      if (iCapture) begin
        op_r <= capVal_s;
      end else if (iHold && hit_s) begin
        op_r <= iWbData;
      end
    end
  end

  assign oAddrRead = addr_r;
  assign oEnRead   = en_r;
  assign oOp       = op_r;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch sequencer: accepts a decoded request, drives the register
// file read ports for READ_LAT cycles and presents both bypassed operands.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_LAT   = 2
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iFlush,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic [ADDR_WIDTH-1:0] iReqAddr0,
  input  logic [ADDR_WIDTH-1:0] iReqAddr1,
  input  logic                  iReqUse0,
  input  logic                  iReqUse1,
  output logic                  oOpValid,
  input  logic                  iOpReady,
  output logic [DATA_WIDTH-1:0] oOp0,
  output logic [DATA_WIDTH-1:0] oOp1,
  output logic [ADDR_WIDTH-1:0] oAddrRead0,
  output logic [ADDR_WIDTH-1:0] oAddrRead1,
  output logic                  oEnRead0,
  output logic                  oEnRead1,
  input  logic [DATA_WIDTH-1:0] iDataRead0,
  input  logic [DATA_WIDTH-1:0] iDataRead1,
  input  logic                  iWbEn,
  input  logic [ADDR_WIDTH-1:0] iWbAddr,
  input  logic [DATA_WIDTH-1:0] iWbData
);

  localparam int CNT_W = $clog2(READ_LAT + 1);

  state_t           state_r;
  state_t           stateNext_s;
  logic [CNT_W-1:0] cnt_r;
  logic             reqReady_r;
  logic             opValid_r;
  logic             accept_s;
  logic             capture_s;
  logic             release_s;
  logic             active_s;
  logic             hold_s;

  // Next-state and phase strobes; flush overrides every handshake
  always_comb begin
    stateNext_s = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    if (iFlush) begin
      stateNext_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iReqValid) begin
            accept_s    = 1'b1;
            stateNext_s = ST_WAIT;
          end else begin
            stateNext_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == CNT_W'(1)) begin
            capture_s   = 1'b1;
            stateNext_s = ST_HOLD;
          end else begin
            stateNext_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (iOpReady) begin
            release_s   = 1'b1;
            stateNext_s = ST_IDLE;
          end else begin
            stateNext_s = ST_HOLD;
          end
        end
        default: stateNext_s = ST_IDLE;
      endcase
    end
  end

  assign active_s = !iFlush && (state_r != ST_IDLE);
  assign hold_s   = !iFlush && (state_r == ST_HOLD);

  // State, latency counter and registered handshake outputs
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      reqReady_r <= 1'b1;
      opValid_r  <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      reqReady_r <= (stateNext_s == ST_IDLE);
      opValid_r  <= (stateNext_s == ST_HOLD);
      if (iFlush) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        cnt_r <= CNT_W'(READ_LAT);
      end else if ((state_r == ST_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign oReqReady = reqReady_r;
  assign oOpValid  = opValid_r;

  operand_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) uSlot0 (
    .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush), .iLoad(accept_s),
    .iActive(active_s), .iCapture(capture_s), .iHold(hold_s), .iRelease(release_s),
    .iReqAddr(iReqAddr0), .iReqUse(iReqUse0), .iWbEn(iWbEn), .iWbAddr(iWbAddr),
    .iWbData(iWbData), .iDataRead(iDataRead0), .oAddrRead(oAddrRead0),
    .oEnRead(oEnRead0), .oOp(oOp0)
  );

  operand_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) uSlot1 (
    .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush), .iLoad(accept_s),
    .iActive(active_s), .iCapture(capture_s), .iHold(hold_s), .iRelease(release_s),
    .iReqAddr(iReqAddr1), .iReqUse(iReqUse1), .iWbEn(iWbEn), .iWbAddr(iWbAddr),
    .iWbData(iWbData), .iDataRead(iDataRead1), .oAddrRead(oAddrRead1),
    .oEnRead(oEnRead1), .oOp(oOp1)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a register-file model with one read
// stage, directed scenarios and randomized traffic checked against it.
module tb_operand_fetch;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LAT = 2;

  logic          iClk = 1'b0;
  logic          iRst_n, iFlush, iReqValid, oReqReady;
  logic [AW-1:0] iReqAddr0, iReqAddr1;
  logic          iReqUse0, iReqUse1;
  logic          oOpValid, iOpReady;
  logic [DW-1:0] oOp0, oOp1;
  logic [AW-1:0] oAddrRead0, oAddrRead1;
  logic          oEnRead0, oEnRead1;
  logic [DW-1:0] iDataRead0, iDataRead1;
  logic          iWbEn;
  logic [AW-1:0] iWbAddr;
  logic [DW-1:0] iWbData;

  operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(LAT)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush), .iReqValid(iReqValid),
    .oReqReady(oReqReady), .iReqAddr0(iReqAddr0), .iReqAddr1(iReqAddr1),
    .iReqUse0(iReqUse0), .iReqUse1(iReqUse1), .oOpValid(oOpValid),
    .iOpReady(iOpReady), .oOp0(oOp0), .oOp1(oOp1), .oAddrRead0(oAddrRead0),
    .oAddrRead1(oAddrRead1), .oEnRead0(oEnRead0), .oEnRead1(oEnRead1),
    .iDataRead0(iDataRead0), .iDataRead1(iDataRead1), .iWbEn(iWbEn),
    .iWbAddr(iWbAddr), .iWbData(iWbData)
  );

  always #5 iClk = ~iClk;

  // Register file model: writes commit at the edge, reads take one stage
  logic [DW-1:0] mem [32];
  always @(posedge iClk) begin
    iDataRead0 <= mem[oAddrRead0];
    iDataRead1 <= mem[oAddrRead1];
    if (iWbEn) mem[iWbAddr] <= iWbData;
  end

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural operand value: r0 and unused operands read as zero,
  // otherwise the newest committed contents of the register.
  function automatic logic [DW-1:0] refOp(input logic [AW-1:0] a, input logic u);
    if (!u || a == 5'd0) return 32'd0;
    return mem[a];
  endfunction

  typedef struct {
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          u0;
    logic          u1;
    int            acc;
  } txn_t;

  txn_t q[$];
  bit   seenValid = 1'b0;
  bit   spacingOn = 1'b0;
  bit   haveLast  = 1'b0;
  int   lastAcc   = 0;

  // Monitor: records accepted requests and scores every delivered operand pair
  always @(negedge iClk) begin
    if (!iRst_n) begin
      q.delete();
      seenValid = 1'b0;
      haveLast  = 1'b0;
    end else if (iFlush) begin
      if (!oReqReady && q.size() > 0) q.delete(0);
      seenValid = 1'b0;
    end else begin
      if (!spacingOn) haveLast = 1'b0;
      if (oReqReady && iReqValid) begin
        txn_t t;
        t.a0 = iReqAddr0; t.a1 = iReqAddr1; t.u0 = iReqUse0; t.u1 = iReqUse1;
        t.acc = cyc + 1;
        if (spacingOn && haveLast) check("accept_spacing", t.acc - lastAcc, LAT + 2);
        lastAcc  = t.acc;
        haveLast = 1'b1;
        q.push_back(t);
      end else if (!oReqReady && !oOpValid) begin
        check("wait_has_txn", q.size() > 0, 1);
        if (q.size() > 0) begin
          check("wait_addr0", oAddrRead0, q[0].a0);
          check("wait_addr1", oAddrRead1, q[0].a1);
          check("wait_en0", oEnRead0, q[0].u0);
          check("wait_en1", oEnRead1, q[0].u1);
        end
      end
      if (oOpValid) begin
        check("valid_has_txn", q.size() > 0, 1);
        if (q.size() > 0) begin
          if (!seenValid) check("op_latency", cyc - q[0].acc, LAT);
          seenValid = 1'b1;
          check("ready_low_in_hold", oReqReady, 0);
          if (iOpReady) begin
            check("op0", oOp0, refOp(q[0].a0, q[0].u0));
            check("op1", oOp1, refOp(q[0].a1, q[0].u1));
            q.delete(0);
            seenValid = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic sendReq(input logic [AW-1:0] a0, input logic u0,
                         input logic [AW-1:0] a1, input logic u1);
    iReqValid = 1'b1; iReqAddr0 = a0; iReqUse0 = u0; iReqAddr1 = a1; iReqUse1 = u1;
    for (int k = 0; k < 20 && !oReqReady; k++) tick();
    check("req_ready_timeout", oReqReady, 1);
    tick();
    iReqValid = 1'b0;
  endtask

  task automatic waitValid();
    for (int k = 0; k < 20 && !oOpValid; k++) tick();
    check("op_valid_timeout", oOpValid, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_ready"}, oReqReady, 1);
    check({tag, "_valid"}, oOpValid, 0);
    check({tag, "_op0"}, oOp0, 32'd0);
    check({tag, "_op1"}, oOp1, 32'd0);
    check({tag, "_addr"}, {oAddrRead0, oAddrRead1}, 10'd0);
    check({tag, "_en"}, {oEnRead0, oEnRead1}, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst_n = 1'b0; iFlush = 1'b0; iReqValid = 1'b0; iOpReady = 1'b0;
    iReqAddr0 = 5'd0; iReqAddr1 = 5'd0; iReqUse0 = 1'b0; iReqUse1 = 1'b0;
    iWbEn = 1'b0; iWbAddr = 5'd0; iWbData = 32'd0;
    tick(); tick();
    checkResetOutputs("reset");
    iRst_n = 1'b1;
    tick();

    // Preload the register file through the writeback port
    for (int i = 0; i < 32; i++) begin
      iWbEn = 1'b1; iWbAddr = AW'(i); iWbData = $urandom;
      if (i == 3) iWbData = 32'hA5A5_0003;
      if (i == 7) iWbData = 32'h0000_0077;
      if (i == 9) iWbData = 32'h1111_0009;
      tick();
    end
    iWbEn = 1'b0;

    // Plain read
    iOpReady = 1'b1;
    sendReq(5'd3, 1'b1, 5'd7, 1'b1);
    waitValid();
    check("read_op0", oOp0, 32'hA5A5_0003);
    check("read_op1", oOp1, 32'h0000_0077);
    tick(); tick();

    // r0 and unused operand, with a writeback to r0 during WAIT
    sendReq(5'd0, 1'b1, 5'd5, 1'b0);
    check("zero_en1", oEnRead1, 0);
    check("zero_en0", oEnRead0, 1);
    iWbEn = 1'b1; iWbAddr = 5'd0; iWbData = 32'hFFFF_FFFF;
    tick();
    iWbEn = 1'b0;
    waitValid();
    check("zero_op0", oOp0, 32'd0);
    check("zero_op1", oOp1, 32'd0);
    tick(); tick();

    // Bypass in WAIT cycle 1 and on the capture edge
    sendReq(5'd9, 1'b1, 5'd9, 1'b1);
    iWbEn = 1'b1; iWbAddr = 5'd9; iWbData = 32'h0000_1234;
    tick();
    iWbData = 32'h0000_5678;
    tick();
    iWbEn = 1'b0;
    waitValid();
    check("byp_op0", oOp0, 32'h0000_5678);
    check("byp_op1", oOp1, 32'h0000_5678);
    tick(); tick();

    // Backpressure with a writeback landing in HOLD
    iOpReady = 1'b0;
    sendReq(5'd9, 1'b1, 5'd3, 1'b1);
    waitValid();
    iWbEn = 1'b1; iWbAddr = 5'd9; iWbData = 32'h0000_BEEF;
    tick();
    iWbEn = 1'b0;
    check("bp_op0", oOp0, 32'h0000_BEEF);
    check("bp_op1", oOp1, 32'hA5A5_0003);
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", oReqReady, 0);
      check("bp_valid", oOpValid, 1);
      tick();
    end
    iOpReady = 1'b1;
    tick();
    check("bp_release_ready", oReqReady, 1);
    check("bp_release_valid", oOpValid, 0);

    // Flush in WAIT
    sendReq(5'd3, 1'b1, 5'd7, 1'b1);
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    check("flush_ready", oReqReady, 1);
    for (int k = 0; k < 5; k++) begin
      check("flush_no_valid", oOpValid, 0);
      tick();
    end

    // Asynchronous reset in HOLD
    iOpReady = 1'b0;
    sendReq(5'd7, 1'b1, 5'd3, 1'b1);
    waitValid();
    iRst_n = 1'b0;
    #1;
    checkResetOutputs("rst_hold");
    tick();
    iRst_n = 1'b1;
    iOpReady = 1'b1;
    tick();

    // Back-to-back requests with random addresses and writebacks
    spacingOn = 1'b1;
    iReqValid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      iReqAddr0 = AW'($urandom_range(0, 31)); iReqUse0 = 1'($urandom_range(0, 3) != 0);
      iReqAddr1 = AW'($urandom_range(0, 31)); iReqUse1 = 1'($urandom_range(0, 3) != 0);
      iWbEn = 1'($urandom_range(0, 2) == 0);
      iWbAddr = AW'($urandom_range(0, 15)); iWbData = $urandom;
      tick();
    end
    iReqValid = 1'b0; iWbEn = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    spacingOn = 1'b0;

    // Fully random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      iReqValid = 1'($urandom_range(0, 1));
      iReqAddr0 = AW'($urandom_range(0, 15)); iReqUse0 = 1'($urandom_range(0, 3) != 0);
      iReqAddr1 = AW'($urandom_range(0, 15)); iReqUse1 = 1'($urandom_range(0, 3) != 0);
      iOpReady = 1'($urandom_range(0, 3) != 0);
      iWbEn = 1'($urandom_range(0, 1));
      iWbAddr = AW'($urandom_range(0, 15)); iWbData = $urandom;
      tick();
    end
    iReqValid = 1'b0; iWbEn = 1'b0; iOpReady = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
